wb_bram_ctrl: RTL



---
 rtl/wb_bram_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_bram_ctrl.sv
// -----------------------------------------------------------------------------
// wb_bram_ctrl
//
// Wishbone slave in front of a 2^ADDR_W x 32-bit block RAM. Every accepted
// request waits a fixed number of cycles (DELAYS) before it is performed and
// acknowledged. This emulates a slow peripheral while the storage itself stays
// an ordinary synchronous RAM.
//
// A request is taken in IDLE when cyc, stb, at least one byte enable and the
// top address byte (== BASE_HI) all hold. Command, byte enables, word index and
// write data are latched at acceptance, so later changes on the bus during the
// wait have no effect. The RAM access and the acknowledge both happen at the
// edge that enters ACK. Dropping cyc while waiting abandons the request
// silently.
//
// Parameters
//   DELAYS  : cycles from the accepting edge to the edge that raises ack (1..255)
//   ADDR_W  : word-address width; RAM depth is 2^ADDR_W words
//   BASE_HI : required value of wbs_adr_i[31:24]
//
// Ports
//   wb_clk_i   in   1  clock, all state changes on the rising edge
//   wb_rst_i   in   1  asynchronous reset, active low
//   wbs_cyc_i  in   1  Wishbone cycle valid
//   wbs_stb_i  in   1  Wishbone strobe
//   wbs_we_i   in   1  1 = write, 0 = read
//   wbs_sel_i  in   4  byte enables, bit n covers dat[8n+7:8n]
//   wbs_adr_i  in  32  byte address
//   wbs_dat_i  in  32  write data
//   wbs_ack_o  out  1  one-cycle transfer acknowledge (registered)
//   wbs_dat_o  out 32  read data, held until the next read completes
//   busy_o     out  1  high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module wb_bram_ctrl #(
  parameter int          DELAYS  = 10,
  parameter int          ADDR_W  = 10,
  parameter logic [7:0]  BASE_HI = 8'h38
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        busy_o
);

  localparam int         DEPTH    = 1 << ADDR_W;
  // The counter is loaded with DELAYS-1. It reaches zero DELAYS-1 edges after
  // acceptance, so the move to ACK happens on edge number DELAYS.
  localparam logic [7:0] CNT_LOAD = 8'(DELAYS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic                ack_reg, ack_next;

  // Request captured at acceptance.
  logic                we_reg;
  logic [3:0]          sel_reg;
  logic [ADDR_W-1:0]   adr_reg;
  logic [31:0]         dat_reg;

  logic                req_hit;
  logic                accept;
  logic                finish;
  logic                wr_en;
  logic                rd_en;
  logic [31:0]         rd_data;

  // Address bits that take no part in decoding. The word index aliases
  // modulo the RAM depth, and the byte offset is covered by sel.
  logic                unused_adr_bits;
  assign unused_adr_bits = ^{wbs_adr_i[23:ADDR_W+2], wbs_adr_i[1:0]};

  assign req_hit = wbs_cyc_i & wbs_stb_i & (|wbs_sel_i) &
                   (wbs_adr_i[31:24] == BASE_HI);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_reg <= IDLE;
      cnt_reg   <= 8'd0;
      ack_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= ack_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state, counter, strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ack_next   = 1'b0;
    accept     = 1'b0;
    finish     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (req_hit) begin
          accept     = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = WAIT;
        end
      end

      WAIT: begin
        // Losing cyc takes priority over the counter. A master that gives up
        // on the last wait cycle must not see a late write or ack.
        if (!wbs_cyc_i) begin
          cnt_next   = 8'd0;
          state_next = IDLE;
        end else if (cnt_reg == 8'd0) begin
          finish     = 1'b1;
          ack_next   = 1'b1;
          state_next = ACK;
        end else begin
          cnt_next   = cnt_reg - 8'd1;
        end
      end

      ACK: begin
        // stb seen here belongs to the finished transfer and is never queued.
        state_next = IDLE;
      end

      default: begin
        cnt_next   = 8'd0;
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      we_reg  <= 1'b0;
      sel_reg <= 4'd0;
      adr_reg <= '0;
      dat_reg <= 32'd0;
    end else if (accept) begin
      we_reg  <= wbs_we_i;
      sel_reg <= wbs_sel_i;
      adr_reg <= wbs_adr_i[ADDR_W+1:2];
      dat_reg <= wbs_dat_i;
    end
  end

  // The RAM is touched only on the edge that enters ACK. While reset is low
  // the state is IDLE, so an interrupted transaction can never write.
  assign wr_en = finish & we_reg;
  assign rd_en = finish & ~we_reg;

  // ---------------------------------------------------------------------------
  // Storage: one byte-wide RAM per lane, giving native byte-enable writes.
  // The RAM arrays have no reset, so their contents survive reset. Each
  // lane's read register is cleared by reset and loads only when a read
  // completes, which holds wbs_dat_o across writes and aborted transfers.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte_reg;

      always_ff @(posedge wb_clk_i) begin
        if (wr_en && sel_reg[gi]) begin
          mem[adr_reg] <= dat_reg[8*gi +: 8];
        end
      end

      always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
          rd_byte_reg <= 8'd0;
        end else if (rd_en) begin
          rd_byte_reg <= mem[adr_reg];
        end
      end

      assign rd_data[8*gi +: 8] = rd_byte_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = rd_data;
  assign busy_o    = (state_reg != IDLE);

endmodule
